// File: rtl/data_mem_responder_pkg.sv
// Shared types for the MEM-stage data-memory responder: FSM encoding and bus
// request direction codes.
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } dmr_state_e;

    localparam logic MEM_REQ_READ  = 1'b0;
    localparam logic MEM_REQ_WRITE = 1'b1;

endpackage

// File: rtl/data_mem_responder_write_buffer.sv
// Posted-store FIFO of {word address, data}. Besides the head it exposes the
// entry that becomes the head after a pop, so the bus request can advance
// back-to-back from a registered output.
module data_mem_write_buffer #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [DATA_WIDTH-1:0] next_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr_inc;
    logic                  push_ok;
    logic                  pop_ok;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = push & ~full;
    assign pop_ok     = pop & ~empty;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    // With a single entry, the follower can only be a store arriving this cycle.
    assign next_addr = (count == CNT_W'(1)) ? push_addr : addr_mem[rd_ptr_inc];
    assign next_data = (count == CNT_W'(1)) ? push_data : data_mem[rd_ptr_inc];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr_inc;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: posts stores into a write buffer, drains
// them in order, and serves loads only once the buffer is empty.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int WB_DEPTH        = 4
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic                       cpu_data_mem_write,
    input  logic                       mem_stage_stall,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [DATA_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]      mem_req_wdata,
    input  logic                       mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_resp_rdata
);

    // state   | meaning
    // IDLE    | no bus activity; pick drain or load
    // WR_REQ  | presenting buffered store at FIFO head
    // RD_REQ  | presenting load request
    // RD_WAIT | load accepted, waiting for response
    // RD_DONE | load data valid, hazard released

    localparam int WADDR_W = DATA_ADDR_WIDTH - 2;
    localparam int CNT_W   = $clog2(WB_DEPTH) + 1;

    dmr_state_e             state;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   load_req;
    logic                   wb_push;
    logic                   wb_pop;
    logic                   wb_full;
    logic                   wb_empty;
    logic [CNT_W-1:0]       wb_count;
    logic [CNT_W-1:0]       wb_count_next;
    logic [WADDR_W-1:0]     wb_head_addr;
    logic [WADDR_W-1:0]     wb_next_addr;
    logic [DATA_WIDTH-1:0]  wb_head_data;
    logic [DATA_WIDTH-1:0]  wb_next_data;
    logic                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^{cpu_data_mem_raddr[1:0], cpu_data_mem_waddr[1:0]};

    assign load_req      = cpu_data_mem_read & ~cpu_data_mem_write;
    assign wb_push       = cpu_data_mem_write & ~wb_full & ~mem_stage_stall;
    assign wb_pop        = (state == WR_REQ) & mem_req_ready;
    assign wb_count_next = wb_count + CNT_W'(wb_push) - CNT_W'(wb_pop);

    assign data_mem_hazard = (load_req & (state != RD_DONE)) | (cpu_data_mem_write & wb_full);
    assign data_mem_rdata  = rdata_q;

    data_mem_write_buffer #(
        .ADDR_WIDTH (WADDR_W),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WB_DEPTH)
    ) u_write_buffer (
        .clk       (cpu_clk),
        .rst_n     (cpu_rst_n),
        .push      (wb_push),
        .push_addr (cpu_data_mem_waddr[DATA_ADDR_WIDTH-1:2]),
        .push_data (cpu_data_mem_wdata),
        .pop       (wb_pop),
        .head_addr (wb_head_addr),
        .head_data (wb_head_data),
        .next_addr (wb_next_addr),
        .next_data (wb_next_data),
        .full      (wb_full),
        .empty     (wb_empty),
        .count     (wb_count)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state         <= IDLE;
            rdata_q       <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= MEM_REQ_READ;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req && wb_empty) begin
                        state         <= RD_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= MEM_REQ_READ;
                        mem_req_addr  <= {cpu_data_mem_raddr[DATA_ADDR_WIDTH-1:2], 2'b00};
                    end else if (!wb_empty) begin
                        state         <= WR_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= MEM_REQ_WRITE;
                        mem_req_addr  <= {wb_head_addr, 2'b00};
                        mem_req_wdata <= wb_head_data;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        if (wb_count_next != '0) begin
                            mem_req_addr  <= {wb_next_addr, 2'b00};
                            mem_req_wdata <= wb_next_data;
                        end else begin
                            state         <= IDLE;
                            mem_req_valid <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        state         <= RD_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= mem_resp_rdata;
                        state   <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    if (!mem_stage_stall) state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: CPU ops are issued in program order against a word-memory
// model; bus and load-data monitors pop expectations as the DUT produces them.
module tb_data_mem_responder;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic [31:0] cpu_data_mem_raddr;
    logic        cpu_data_mem_read;
    logic [31:0] cpu_data_mem_waddr;
    logic [31:0] cpu_data_mem_wdata;
    logic        cpu_data_mem_write;
    logic        mem_stage_stall;
    logic [31:0] data_mem_rdata;
    logic        data_mem_hazard;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int checks = 0;
    int errors = 0;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    logic [31:0] model_mem [logic [29:0]];
    logic [31:0] bus_mem   [logic [29:0]];

    int ready_force     = 1;
    int rsp_delay_fixed = 1;
    bit spurious_en     = 0;

    data_mem_responder dut (
        .cpu_clk            (cpu_clk),
        .cpu_rst_n          (cpu_rst_n),
        .cpu_data_mem_raddr (cpu_data_mem_raddr),
        .cpu_data_mem_read  (cpu_data_mem_read),
        .cpu_data_mem_waddr (cpu_data_mem_waddr),
        .cpu_data_mem_wdata (cpu_data_mem_wdata),
        .cpu_data_mem_write (cpu_data_mem_write),
        .mem_stage_stall    (mem_stage_stall),
        .data_mem_rdata     (data_mem_rdata),
        .data_mem_hazard    (data_mem_hazard),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_write      (mem_req_write),
        .mem_req_addr       (mem_req_addr),
        .mem_req_wdata      (mem_req_wdata),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_rdata     (mem_resp_rdata)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    function automatic logic [31:0] default_word(input logic [29:0] wa);
        return {wa, 2'b11} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_word(input logic [29:0] wa);
        return model_mem.exists(wa) ? model_mem[wa] : default_word(wa);
    endfunction

    function automatic logic [31:0] bus_word(input logic [29:0] wa);
        return bus_mem.exists(wa) ? bus_mem[wa] : default_word(wa);
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=timeout required=completion", name);
    endtask

    // Bus memory: accepts writes, answers reads after a delay, optionally
    // injects stray responses while no read is outstanding.
    initial begin
        int          rsp_cnt;
        logic [31:0] rsp_addr;
        rsp_cnt        = 0;
        rsp_addr       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(posedge cpu_clk);
            #2;
            mem_resp_valid = 1'b0;
            mem_req_ready  = (ready_force < 0) ? ($urandom_range(0, 3) != 0) : ready_force[0];
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = bus_word(rsp_addr[31:2]);
                end
            end else if (spurious_en && $urandom_range(0, 5) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = $urandom;
            end
            @(negedge cpu_clk);
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_write) bus_mem[mem_req_addr[31:2]] = mem_req_wdata;
                else begin
                    rsp_addr = mem_req_addr;
                    rsp_cnt  = (rsp_delay_fixed > 0) ? rsp_delay_fixed : int'($urandom_range(1, 3));
                end
            end
        end
    end

    // Bus monitor: ordered request check plus valid/ready stability.
    initial begin
        bus_t        e;
        bit          hold;
        logic [96:0] prev;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge cpu_clk);
            if (!cpu_rst_n) hold = 0;
            else begin
                if (hold)
                    check("req_stable", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata}, prev);
                hold = mem_req_valid & ~mem_req_ready;
                prev = {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata};
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_bus.size() == 0) begin
                        check("bus_unexpected", {mem_req_write, mem_req_addr}, 96'h0);
                        if (mem_req_write == 1'b0 && mem_req_addr == '0) note_fail("bus_unexpected_rd0");
                    end else begin
                        e = exp_bus.pop_front();
                        if (e.wr)
                            check("bus_write", {mem_req_write, mem_req_addr, mem_req_wdata}, {e.wr, e.addr, e.data});
                        else
                            check("bus_read", {mem_req_write, mem_req_addr}, {e.wr, e.addr});
                    end
                end
            end
        end
    end

    // Load-data monitor: data must match program-order memory whenever hazard is low.
    initial begin
        forever begin
            @(negedge cpu_clk);
            if (cpu_rst_n && cpu_data_mem_read && !cpu_data_mem_write && !data_mem_hazard) begin
                if (exp_rd.size() == 0) note_fail("rdata_unexpected");
                else begin
                    check("load_rdata", data_mem_rdata, exp_rd[0]);
                    if (!mem_stage_stall) void'(exp_rd.pop_front());
                end
            end
        end
    end

    // smode: 0 no stall, 1 random stall, 2 stall through two hazard-free cycles
    task automatic cpu_op(input bit is_rd, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] data, input int smode, output int hz);
        bus_t e;
        bit   done;
        bit   s;
        int   free_seen;
        hz        = 0;
        done      = 0;
        free_seen = 0;
        if (is_wr) begin
            e.wr = 1'b1; e.addr = {addr[31:2], 2'b00}; e.data = data;
            exp_bus.push_back(e);
            model_mem[addr[31:2]] = data;
        end else if (is_rd) begin
            e.wr = 1'b0; e.addr = {addr[31:2], 2'b00}; e.data = '0;
            exp_bus.push_back(e);
            exp_rd.push_back(model_word(addr[31:2]));
        end
        cpu_data_mem_raddr = addr;
        cpu_data_mem_waddr = addr;
        cpu_data_mem_wdata = data;
        cpu_data_mem_read  = is_rd;
        cpu_data_mem_write = is_wr;
        for (int c = 0; c < 400 && !done; c++) begin
            case (smode)
                1:       s = ($urandom_range(0, 3) == 0);
                2:       s = (free_seen < 2);
                default: s = 1'b0;
            endcase
            mem_stage_stall = s;
            @(negedge cpu_clk);
            if (data_mem_hazard) hz++;
            else if (!s) done = 1;
            else free_seen++;
            @(posedge cpu_clk);
            #1;
        end
        if (!done) note_fail("cpu_op_timeout");
        cpu_data_mem_read  = 1'b0;
        cpu_data_mem_write = 1'b0;
        mem_stage_stall    = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge cpu_clk);
            ok = (exp_bus.size() == 0) && (exp_rd.size() == 0) && !mem_req_valid;
        end
        if (!ok) note_fail(name);
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        int          hz;
        bit          found;
        logic [31:0] d;
        logic [31:0] a;
        int          r;

        cpu_rst_n          = 1'b0;
        cpu_data_mem_raddr = '0;
        cpu_data_mem_read  = 1'b0;
        cpu_data_mem_waddr = '0;
        cpu_data_mem_wdata = '0;
        cpu_data_mem_write = 1'b0;
        mem_stage_stall    = 1'b0;
        repeat (3) @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;

        @(negedge cpu_clk);
        check("reset_req_valid", mem_req_valid, 0);
        check("reset_req_write", mem_req_write, 0);
        check("reset_req_addr", mem_req_addr, 0);
        check("reset_req_wdata", mem_req_wdata, 0);
        check("reset_rdata", data_mem_rdata, 0);
        check("reset_hazard", data_mem_hazard, 0);
        @(posedge cpu_clk);
        #1;

        // Posted store
        ready_force = 1;
        cpu_op(0, 1, 32'h10, 32'hDEAD_BEEF, 0, hz);
        check("posted_store_hazard", hz, 0);
        found = 0;
        for (int c = 0; c < 4 && !found; c++) begin
            @(negedge cpu_clk);
            if (mem_req_valid) begin
                found = 1;
                check("posted_store_req", {mem_req_write, mem_req_addr, mem_req_wdata},
                      {1'b1, 32'h10, 32'hDEAD_BEEF});
            end
        end
        if (!found) note_fail("posted_store_req_wait");
        drain("posted_store_drain");

        // Load latency on an empty buffer
        rsp_delay_fixed = 1;
        cpu_op(1, 0, 32'h40, 32'h0, 0, hz);
        check("load_latency_stalls", hz, 3);
        drain("load_latency_drain");

        // Full buffer
        ready_force = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_op(0, 1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0, hz);
            check("fill_store_hazard", hz, 0);
        end
        cpu_data_mem_waddr = 32'h10;
        cpu_data_mem_raddr = 32'h10;
        cpu_data_mem_wdata = 32'hA000_0004;
        cpu_data_mem_write = 1'b1;
        @(negedge cpu_clk);
        check("full_hazard_0", data_mem_hazard, 1);
        @(posedge cpu_clk);
        #1;
        @(negedge cpu_clk);
        check("full_hazard_1", data_mem_hazard, 1);
        ready_force = 1;
        @(posedge cpu_clk);
        #1;
        cpu_op(0, 1, 32'h10, 32'hA000_0004, 0, hz);
        check("full_release_stalls", hz, 1);
        drain("full_drain");

        // Load behind buffered stores
        cpu_op(0, 1, 32'h20, 32'h1, 0, hz);
        cpu_op(0, 1, 32'h24, 32'h2, 0, hz);
        cpu_op(1, 0, 32'h22, 32'h0, 0, hz);
        drain("load_behind_drain");

        // Slow bus: ready low while the read is presented, response two cycles later
        ready_force        = 0;
        rsp_delay_fixed    = 2;
        cpu_data_mem_raddr = 32'h26;
        cpu_data_mem_read  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge cpu_clk);
            check("slow_hazard", data_mem_hazard, 1);
            if (c > 0)
                check("slow_req", {mem_req_valid, mem_req_write, mem_req_addr}, {1'b1, 1'b0, 32'h24});
            @(posedge cpu_clk);
            #1;
        end
        ready_force = 1;
        cpu_op(1, 0, 32'h26, 32'h0, 0, hz);
        check("slow_tail_stalls", hz, 3);
        drain("slow_drain");

        // External stall held in RD_DONE
        rsp_delay_fixed = 1;
        cpu_op(1, 0, 32'h0C, 32'h0, 2, hz);
        check("ext_stall_hazard_cycles", hz, 3);
        drain("ext_stall_drain");

        // Reset while the load is in RD_WAIT; response arrives after release
        rsp_delay_fixed = 3;
        begin
            bus_t e;
            e.wr = 1'b0; e.addr = 32'h80; e.data = '0;
            exp_bus.push_back(e);
        end
        cpu_data_mem_raddr = 32'h80;
        cpu_data_mem_read  = 1'b1;
        @(negedge cpu_clk);
        check("rst_load_hazard", data_mem_hazard, 1);
        @(posedge cpu_clk);
        #1;
        @(negedge cpu_clk);
        check("rst_load_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h80});
        @(posedge cpu_clk);
        #1;
        cpu_rst_n         = 1'b0;
        cpu_data_mem_read = 1'b0;
        @(negedge cpu_clk);
        check("rst_req_valid", mem_req_valid, 0);
        @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge cpu_clk);
            check("rst_after_rdata", data_mem_rdata, 0);
            check("rst_after_valid", mem_req_valid, 0);
            @(posedge cpu_clk);
            #1;
        end
        rsp_delay_fixed = 1;
        cpu_op(1, 0, 32'h84, 32'h0, 0, hz);
        check("post_reset_load_stalls", hz, 3);
        drain("post_reset_drain");

        // Randomised traffic
        ready_force     = -1;
        rsp_delay_fixed = 0;
        spurious_en     = 1;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            if (r < 4)      cpu_op(0, 1, a, d, 1, hz);
            else if (r < 5) cpu_op(1, 1, a, d, 1, hz);
            else if (r < 8) cpu_op(1, 0, a, d, 1, hz);
            else            cpu_op(0, 0, a, d, 1, hz);
        end
        spurious_en = 0;
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
